// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: read-domain output stage of the async FIFO.
// Turns the empty/rd_en pull interface of the FIFO RAM into a
// first-word-fall-through valid/ready stream. A 3-entry prefetch buffer covers
// the 1-cycle RAM latency, so a consumer that is always ready gets one word per
// r_clk. rd_en depends only on registered state, fifo_empty and rst. It has no
// path from out_ready.
// Optional build macro RD_FWFT_STATS_EN adds the xfer_cnt/stall_cnt outputs.
module fifo_rd_fwft #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              r_clk,
   input  logic              rst,
   input  logic              fifo_empty,
   output logic              rd_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef RD_FWFT_STATS_EN
   ,
   output logic [15:0]       xfer_cnt,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int unsigned DEPTH = 3;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned OUT_W = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   // Prefetch buffer and its bookkeeping.
   logic [DATA_W-1:0] store_q [DEPTH];
   logic [DATA_W-1:0] store_d [DEPTH];
   logic [IDX_W-1:0]  head_q, head_d;
   logic [IDX_W-1:0]  tail_q, tail_d;
   logic [IDX_W-1:0]  occ_q, occ_d;
   logic              inflight_q;

   logic              push;
   logic              pop;
   logic [OUT_W-1:0]  outstanding_c;
   logic              out_valid_d;
   logic [DATA_W-1:0] out_data_d;

   // Advance a circular-buffer index, wrapping after the last entry.
   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      return (idx == LAST_IDX) ? IDX_W'(0) : IDX_W'(idx + IDX_W'(1));
   endfunction

   // Issue a RAM read only when every word already requested still has room.
   always_comb begin
      outstanding_c = OUT_W'(occ_q) + OUT_W'(inflight_q);
      rd_en         = ~rst & ~fifo_empty & (outstanding_c < OUT_W'(DEPTH));
   end

   // Next-state logic: write returning RAM data at tail, pop at head, and
   // precompute the head word so out_data can come straight from a flop.
   always_comb begin
      push    = inflight_q;
      pop     = out_valid & out_ready;
      store_d = store_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (push) begin
         store_d[tail_q] = mem_rdata;
         tail_d          = idx_inc(tail_q);
      end
      if (pop) begin
         head_d = idx_inc(head_q);
      end
      occ_d       = IDX_W'(OUT_W'(occ_q) + OUT_W'(push) - OUT_W'(pop));
      out_valid_d = (occ_d != IDX_W'(0));
      out_data_d  = store_d[head_d];
   end

   // State registers. Reset drops buffered and in-flight words at once.
   always_ff @(posedge r_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            store_q[i] <= '0;
         end
         head_q     <= '0;
         tail_q     <= '0;
         occ_q      <= '0;
         inflight_q <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         store_q    <= store_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
         inflight_q <= rd_en;
         out_valid  <= out_valid_d;
         out_data   <= out_data_d;
      end
   end

`ifdef RD_FWFT_STATS_EN
   // Transfer counter wraps. The stall counter saturates at all-ones.
   always_ff @(posedge r_clk or posedge rst) begin
      if (rst) begin
         xfer_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop) begin
            xfer_cnt <= xfer_cnt + 16'd1;
         end
         if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

`ifndef SYNTHESIS
   // Storage can never be oversubscribed.
   a_no_overflow : assert property (@(posedge r_clk) disable iff (rst)
      outstanding_c <= OUT_W'(DEPTH));

   // A returning word always finds a free entry.
   a_push_has_room : assert property (@(posedge r_clk) disable iff (rst)
      !(push && (occ_q == IDX_W'(DEPTH))));

   // The RAM is never popped while it is empty.
   a_no_rd_when_empty : assert property (@(posedge r_clk) disable iff (rst)
      !(rd_en && fifo_empty));

   // out_valid is a registered copy of occupancy != 0.
   a_valid_matches_occ : assert property (@(posedge r_clk) disable iff (rst)
      out_valid == (occ_q != IDX_W'(0)));
`endif

endmodule

// File: doc/fifo_rd_fwft.md
Name: fifo_rd_fwft

Overview:
- Read-domain output stage of the async FIFO, directly downstream of the read-pointer/empty logic and the dual-port RAM read port.
- Converts the FIFO's empty/rd_en (pull) interface into a first-word-fall-through valid/ready stream for the consumer.
- Holds up to 3 words in a small prefetch buffer so that a continuously ready consumer receives one word per r_clk.
- Has no combinational path from out_ready to rd_en.

Parameters:
- DATA_W, 8, width of a FIFO word and of out_data.

Ports:
- r_clk  input  1  read-domain clock; all logic is posedge r_clk.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  empty flag from the read-pointer logic (write pointer synchronised into r_clk).
- rd_en  output  1  pop request to the read-pointer logic; advances r_ptr one word.
- mem_rdata  input  DATA_W  RAM read data. Valid in the cycle after the rd_en it answers (synchronous RAM, 1-cycle latency).
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  DATA_W  head word, registered.

Behaviour:
- Reset (async, immediate): occupancy=0, inflight=0, rd_en=0, out_valid=0, out_data=0, buffer contents=0.
- Reset mid-operation discards buffered and in-flight words. The RAM pointer resets together with this block (same rst), so no realignment is needed.
- Internal state:
  - 3-entry circular buffer: head index, tail index, each 2 bits, wrapping 2->0.
  - occupancy, 2 bits, range 0..3.
  - inflight flag, 1 bit.
- rd_en = ~fifo_empty & ((occupancy + inflight) < 3).
  - Depends only on registered state and fifo_empty.
  - Never asserted while fifo_empty=1.
- inflight next = rd_en. mem_rdata is written at tail on the edge ending the cycle after rd_en.
- pop = out_valid & out_ready.
- push = inflight. Push is always accepted, because issue was gated by free space.
- occupancy next = occupancy + push - pop. Simultaneous push and pop leave occupancy unchanged; head and tail both advance.
- out_valid = (occupancy != 0). out_data = buffer[head]. Both are driven from registers.
- Latency:
  - fifo_empty falls in cycle T with the buffer empty -> rd_en high in T -> mem_rdata in T+1 -> out_valid=1 in T+2.
  - Steady streaming with out_ready=1: one word per cycle, occupancy settles at 1 and inflight at 1.
- Backpressure with out_ready=0: at most 3 words are stored, then rd_en stays low until a pop.
- Ordering: words are delivered strictly in FIFO order, with no loss or duplication.
- out_data must remain stable while out_valid=1 and out_ready=0.
- Prohibited: occupancy >3, push when occupancy+inflight would exceed 3, rd_en with fifo_empty=1. These are assertion targets.

Optional Feature:
- Macro: RD_FWFT_STATS_EN.
- Defined:
  - Adds output xfer_cnt[15:0], incremented on each pop and wrapping at 16'hFFFF->0.
  - Adds output stall_cnt[15:0], incremented each cycle with out_valid=1 and out_ready=0; saturates at 16'hFFFF.
  - Both counters reset to 0.
- Undefined: neither port nor the counters exist. Core behaviour is identical either way.

Test Plan:
- Reset with fifo_empty=1 for 10 cycles -> rd_en=0, out_valid=0, out_data=0 throughout.
- FIFO preloaded with 0x11,0x22,0x33,0x44; fifo_empty=0 from cycle T; out_ready=1 -> rd_en high from T; out_valid from T+2; out_data 0x11,0x22,0x33,0x44 on consecutive cycles; no bubbles.
- Same preload, out_ready=0 -> exactly 3 rd_en pulses; out_data holds 0x11 stable; raise out_ready -> 0x11..0x44 delivered in order.
- Random out_ready (50%) over a 200-word stream with random fifo_empty gaps -> scoreboard shows exact order, no duplicates or drops; rd_en never high while fifo_empty=1.
- Assert rst while occupancy=2 and inflight=1 -> next cycle out_valid=0, rd_en=0; after release, the stream restarts from the new FIFO contents.
- With RD_FWFT_STATS_EN: 5 pops, then 4 stalled cycles -> xfer_cnt=5, stall_cnt=4; force 65540 stall cycles -> stall_cnt=16'hFFFF.
